// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage multiply/divide sequencer and owner of the architectural HI/LO registers.
// Drives the external multiplier/divider, stalls IF..EX until HI/LO commit, and honours flush.
module muldiv_hilo_ctrl #(
   parameter int unsigned MUL_LAT   = 2,
   parameter bit          DIV0_FAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   input  logic [63:0] mul_prod,
   output logic        div_en,
   output logic        div_sign,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_res_ready,
   input  logic [31:0] div_s,
   input  logic [31:0] div_r,
   output logic        stall_req,
   output logic        busy,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               div0_q, div0_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        mul_a_q, mul_a_d;
   logic [31:0]        mul_b_q, mul_b_d;
   logic               mul_sign_q, mul_sign_d;
   logic               div_en_q, div_en_d;
   logic               div_sign_q, div_sign_d;
   logic [31:0]        div_a_q, div_a_d;
   logic [31:0]        div_b_q, div_b_d;
   logic               accept;

   assign accept = (state_q == ST_IDLE) && op_valid && !flush;

   // Next-state, HI/LO commit and stall decode; flush always wins over a same-cycle commit
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div0_d     = div0_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_sign_d = mul_sign_q;
      div_en_d   = div_en_q;
      div_sign_d = div_sign_q;
      div_a_d    = div_a_q;
      div_b_d    = div_b_q;
      stall_req  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     mul_a_d    = src_a;
                     mul_b_d    = src_b;
                     mul_sign_d = (op == OP_MULT);
                     cnt_d      = CNT_W'(MUL_LAT);
                     state_d    = ST_MUL;
                     stall_req  = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     div_a_d    = src_a;
                     div_b_d    = src_b;
                     div_sign_d = (op == OP_DIV);
                     state_d    = ST_DIV;
                     stall_req  = 1'b1;
                     // A zero divisor bypasses the divider and commits on the next edge
                     if (DIV0_FAST && (src_b == 32'd0)) begin
                        div0_d = 1'b1;
                     end else begin
                        div_en_d = 1'b1;
                     end
                  end
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end
         end

         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               hi_d    = mul_prod[63:32];
               lo_d    = mul_prod[31:0];
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d     = cnt_q - CNT_W'(1);
               stall_req = 1'b1;
            end
         end

         ST_DIV: begin
            if (flush) begin
               state_d  = ST_IDLE;
               div_en_d = 1'b0;
               div0_d   = 1'b0;
            end else if (div0_q) begin
               hi_d    = div_a_q;
               lo_d    = 32'hFFFF_FFFF;
               state_d = ST_IDLE;
               div0_d  = 1'b0;
            end else if (div_res_ready) begin
               hi_d     = div_r;
               lo_d     = div_s;
               state_d  = ST_IDLE;
               div_en_d = 1'b0;
            end else begin
               stall_req = 1'b1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            div_en_d = 1'b0;
            div0_d   = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div0_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_sign_q <= 1'b0;
         div_en_q   <= 1'b0;
         div_sign_q <= 1'b0;
         div_a_q    <= '0;
         div_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div0_q     <= div0_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_sign_q <= mul_sign_d;
         div_en_q   <= div_en_d;
         div_sign_q <= div_sign_d;
         div_a_q    <= div_a_d;
         div_b_q    <= div_b_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;
   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;
   assign mul_sign = mul_sign_q;
   assign div_en   = div_en_q;
   assign div_sign = div_sign_q;
   assign div_a    = div_a_q;
   assign div_b    = div_b_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: stimulus queues expected HI/LO commits,
// a forked monitor checks each HI/LO change against the queue head and its commit cycle.
module tb_muldiv_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic [31:0] mul_a, mul_b;
   logic        mul_sign;
   logic [63:0] mul_prod;
   logic        div_en, div_sign;
   logic [31:0] div_a, div_b;
   logic        div_res_ready;
   logic [31:0] div_s, div_r;
   logic        stall_req, busy;
   logic [31:0] hi_o, lo_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int den_cnt = 0;
   int div_cyc = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   muldiv_hilo_ctrl #(.MUL_LAT(2), .DIV0_FAST(1'b1)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign), .mul_prod(mul_prod),
      .div_en(div_en), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
      .div_res_ready(div_res_ready), .div_s(div_s), .div_r(div_r),
      .stall_req(stall_req), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   // Divider model: result ready in the 33rd cycle of div_en
   always_ff @(posedge clk) begin
      if (div_en) begin
         den_cnt <= den_cnt + 1;
         div_cyc <= div_cyc + 1;
      end else begin
         div_cyc <= 0;
      end
   end
   assign div_res_ready = div_en && (div_cyc == 32);

   always_comb begin
      div_s = '0;
      div_r = '0;
      if (div_b != 32'd0) begin
         if (div_sign) begin
            div_s = $signed(div_a) / $signed(div_b);
            div_r = $signed(div_a) % $signed(div_b);
         end else begin
            div_s = div_a / div_b;
            div_r = div_a % div_b;
         end
      end
   end

   logic [63:0] ext_a, ext_b;
   always_comb begin
      ext_a    = mul_sign ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
      ext_b    = mul_sign ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
      mul_prod = ext_a * ext_b;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic monitor();
      logic [63:0] prev, cur;
      exp_t e;
      prev = {hi_o, lo_o};
      forever begin
         @(negedge clk);
         cur = {hi_o, lo_o};
         if (cur !== prev) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_change", cur, prev);
            end else begin
               e = sbq.pop_front();
               chk("sb_hilo", cur, {e.hi, e.lo});
               if (e.cyc >= 0) chk("sb_commit_cycle", 64'(cyc), 64'(e.cyc));
            end
            prev = cur;
         end
      end
   endtask

   // Present an op at a negedge, hold it while stalled; lat=0 means no HI/LO change expected
   task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int exp_stall);
      int c, n;
      c = cyc;
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      if (lat > 0) sbq.push_back('{exp_hi, exp_lo, c + lat});
      n = 0;
      forever begin
         #1;
         if (!stall_req) break;
         n++;
         if (n > 100) begin
            chk({nm, "_stall_timeout"}, 64'(n), 64'(exp_stall));
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
   endtask

   initial begin
      int d0, n;
      repeat (3) @(negedge clk);
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      chk("rst_busy_diven", {62'd0, busy, div_en}, 64'd0);
      chk("rst_operands", {mul_a, div_a}, 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      fork
         monitor();
      join_none

      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
      issue("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 3, 2);
      chk("mult_busy_after", 64'(busy), 64'd0);

      d0 = den_cnt;
      exp_hi = 32'd2; exp_lo = 32'd14;
      issue("divu", 3'd3, 32'd100, 32'd7, 34, 33);
      chk("divu_diven_cycles", 64'(den_cnt - d0), 64'd33);
      chk("divu_diven_after", 64'(div_en), 64'd0);

      d0 = den_cnt;
      exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
      issue("div0", 3'd2, 32'd5, 32'd0, 2, 1);
      chk("div0_diven_cycles", 64'(den_cnt - d0), 64'd0);

      exp_hi = 32'hDEAD_BEEF;
      issue("mthi", 3'd4, 32'hDEAD_BEEF, 32'd0, 1, 0);
      exp_lo = 32'h0000_1234;
      issue("mtlo", 3'd5, 32'h0000_1234, 32'd0, 1, 0);

      issue("op6", 3'd6, 32'h5555_5555, 32'd1, 0, 0);
      issue("op7", 3'd7, 32'hAAAA_AAAA, 32'd1, 0, 0);
      chk("op67_busy", 64'(busy), 64'd0);

      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
      issue("div_signed", 3'd2, 32'hFFFF_FFF9, 32'd2, 34, 33);

      // Flush arriving in the same cycle as the divider result
      op_valid = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd5;
      n = 0;
      while (!div_res_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("flush_ready_seen", 64'(div_res_ready), 64'd1);
      flush = 1'b1;
      #1;
      chk("flush_stall", 64'(stall_req), 64'd0);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      op_valid = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_diven", 64'(div_en), 64'd0);
      chk("flush_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
      @(negedge clk);
      chk("flush_diven_later", 64'(div_en), 64'd0);

      // Asynchronous reset in the middle of a divide
      op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      exp_hi = '0; exp_lo = '0;
      sbq.push_back('{exp_hi, exp_lo, -1});
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
      chk("mid_rst_diven", 64'(div_en), 64'd0);
      op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      exp_hi = 32'd3; exp_lo = 32'd0;
      issue("multu_after_rst", 3'd1, 32'h0001_0000, 32'h0003_0000, 3, 2);

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
